// File: rtl/tdm_demux_1in_4out_pkg.sv
// Shared definitions for the 4-slot TDM demultiplexer: slot geometry,
// FSM state encoding and a small slot-index helper.
package tdm_demux_1in_4out_pkg;

    localparam int NSLOT  = 4;
    localparam int SLOT_W = 2;

    localparam logic [SLOT_W-1:0] FIRST_SLOT = 2'd0;
    localparam logic [SLOT_W-1:0] LAST_SLOT  = 2'(NSLOT - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Next slot index with natural 2-bit wrap (3 -> 0).
    function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] slot);
        return slot + 2'd1;
    endfunction

endpackage

// File: rtl/tdm_demux_1in_4out_slot_counter.sv
// Slot counter for the TDM demultiplexer: holds the index of the slot the
// next accepted sample goes to. Clear wins over a sync load, which wins over
// a plain advance.
module tdm_demux_1in_4out_slot_counter
    import tdm_demux_1in_4out_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load_one,
    input  logic              advance,
    output logic [SLOT_W-1:0] sel
);

    // Slot index register: a sync-marked sample occupies slot 0, so the
    // following sample lands in slot 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= FIRST_SLOT;
        end else if (clear) begin
            sel <= FIRST_SLOT;
        end else if (load_one) begin
            sel <= 2'd1;
        end else if (advance) begin
            sel <= slot_inc(sel);
        end
    end

endmodule

// File: rtl/tdm_demux_1in_4out.sv
// Receive side of a 4-into-1 TDM link. Samples are collected into a shadow
// buffer and all four channels are published to Q together once a complete,
// correctly aligned frame has been received.
module tdm_demux_1in_4out
    import tdm_demux_1in_4out_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       D,
    input  logic                   valid_in,
    input  logic                   sync,
    output logic [NSLOT*WIDTH-1:0] Q,
    output logic                   frame_valid,
    output logic [SLOT_W-1:0]      sel,
    output logic                   locked,
    output logic                   sync_err
);

    state_t            state;
    state_t            state_next;

    // Slot 3 never needs storage: it is taken straight from D on the
    // publishing edge, so only slots 0..2 are buffered.
    logic [WIDTH-1:0]  shadow [0:NSLOT-2];

    logic              wr_en;
    logic [SLOT_W-1:0] wr_idx;
    logic              publish;
    logic              err_next;
    logic              cnt_clear;
    logic              cnt_load;
    logic              cnt_advance;

    tdm_demux_1in_4out_slot_counter u_slot_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .load_one (cnt_load),
        .advance  (cnt_advance),
        .sel      (sel)
    );

    // Frame-alignment FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus per-sample buffer, publish and error controls.
    always_comb begin
        state_next  = state;
        wr_en       = 1'b0;
        wr_idx      = FIRST_SLOT;
        publish     = 1'b0;
        err_next    = 1'b0;
        cnt_clear   = 1'b0;
        cnt_load    = 1'b0;
        cnt_advance = 1'b0;
        if (valid_in) begin
            unique case (state)
                HUNT: begin
                    if (sync) begin
                        wr_en      = 1'b1;
                        cnt_load   = 1'b1;
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        err_next = (sel != FIRST_SLOT);
                        wr_en    = 1'b1;
                        cnt_load = 1'b1;
                    end else if (sel == FIRST_SLOT) begin
                        err_next   = 1'b1;
                        cnt_clear  = 1'b1;
                        state_next = HUNT;
                    end else begin
                        cnt_advance = 1'b1;
                        if (sel == LAST_SLOT) begin
                            publish = 1'b1;
                        end else begin
                            wr_en  = 1'b1;
                            wr_idx = sel;
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    // Shadow buffer: collects slots 0..2 of the frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT - 1; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_en) begin
            shadow[wr_idx] <= D;
        end
    end

    // Output bank: Q only ever changes as a whole frame, alongside the
    // one-cycle frame_valid and sync_err pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= publish;
            sync_err    <= err_next;
            if (publish) begin
                Q <= {D, shadow[2], shadow[1], shadow[0]};
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1in_4out.sv
// Directed self-checking bench for tdm_demux_1in_4out with 8-bit samples.
// Inputs change on the falling edge; outputs are checked on the following
// falling edge, i.e. half a cycle after the rising edge that consumed them.
module tb_tdm_demux_1in_4out;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] D;
    logic             valid_in;
    logic             sync;
    logic [4*WIDTH-1:0] Q;
    logic             frame_valid;
    logic [1:0]       sel;
    logic             locked;
    logic             sync_err;

    int check_count = 0;
    int pass_count  = 0;

    tdm_demux_1in_4out #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .D           (D),
        .valid_in    (valid_in),
        .sync        (sync),
        .Q           (Q),
        .frame_valid (frame_valid),
        .sel         (sel),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one input cycle, then wait until the next falling edge so the
    // outputs reflect the rising edge that consumed it.
    task automatic apply_stimulus(input logic v, input logic s, input logic [WIDTH-1:0] d);
        valid_in = v;
        sync     = s;
        D        = d;
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    initial begin
        valid_in = 1'b0;
        sync     = 1'b0;
        D        = '0;
        rst_n    = 1'b0;

        // Reset state, visible without any clock edge
        #3;
        check_output("reset_q",        Q,           32'h0);
        check_output("reset_sel",      32'(sel),    32'd0);
        check_output("reset_locked",   32'(locked), 32'd0);
        check_output("reset_fv",       32'(frame_valid), 32'd0);
        check_output("reset_err",      32'(sync_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Hunting: unsynced samples are discarded
        apply_stimulus(1'b1, 1'b0, 8'h5A);
        apply_stimulus(1'b1, 1'b0, 8'h6B);
        check_output("hunt_locked",    32'(locked), 32'd0);
        check_output("hunt_sel",       32'(sel),    32'd0);
        check_output("hunt_err",       32'(sync_err), 32'd0);

        // Clean back-to-back frame
        apply_stimulus(1'b1, 1'b1, 8'hA1);
        check_output("clean_lock",     32'(locked), 32'd1);
        check_output("clean_sel1",     32'(sel),    32'd1);
        apply_stimulus(1'b1, 1'b0, 8'hB2);
        check_output("clean_sel2",     32'(sel),    32'd2);
        apply_stimulus(1'b1, 1'b0, 8'hC3);
        check_output("clean_q_hold",   Q,           32'h0);
        check_output("clean_fv_early", 32'(frame_valid), 32'd0);
        apply_stimulus(1'b1, 1'b0, 8'hD4);
        check_output("clean_q",        Q,           32'hD4C3B2A1);
        check_output("clean_fv",       32'(frame_valid), 32'd1);
        check_output("clean_sel_wrap", 32'(sel),    32'd0);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("clean_fv_pulse", 32'(frame_valid), 32'd0);
        check_output("clean_q_keep",   Q,           32'hD4C3B2A1);

        // Gapped frame; sync on an idle cycle must be ignored
        apply_stimulus(1'b1, 1'b1, 8'h01);
        apply_stimulus(1'b0, 1'b0, 8'hFF);
        check_output("gap_sel_hold",   32'(sel),    32'd1);
        apply_stimulus(1'b0, 1'b1, 8'hEE);
        check_output("gap_idle_sync",  32'(sel),    32'd1);
        check_output("gap_idle_err",   32'(sync_err), 32'd0);
        apply_stimulus(1'b1, 1'b0, 8'h02);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b1, 1'b0, 8'h03);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("gap_sel3",       32'(sel),    32'd3);
        check_output("gap_q_hold",     Q,           32'hD4C3B2A1);
        apply_stimulus(1'b1, 1'b0, 8'h04);
        check_output("gap_q",          Q,           32'h04030201);
        check_output("gap_fv",         32'(frame_valid), 32'd1);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("gap_fv_pulse",   32'(frame_valid), 32'd0);

        // Early sync drops the partial frame
        apply_stimulus(1'b1, 1'b1, 8'h11);
        apply_stimulus(1'b1, 1'b0, 8'h22);
        apply_stimulus(1'b1, 1'b1, 8'h33);
        check_output("early_err",      32'(sync_err), 32'd1);
        check_output("early_sel",      32'(sel),    32'd1);
        check_output("early_locked",   32'(locked), 32'd1);
        check_output("early_q_hold",   Q,           32'h04030201);
        apply_stimulus(1'b1, 1'b0, 8'h44);
        check_output("early_err_pulse", 32'(sync_err), 32'd0);
        apply_stimulus(1'b1, 1'b0, 8'h55);
        check_output("early_fv_none",  32'(frame_valid), 32'd0);
        apply_stimulus(1'b1, 1'b0, 8'h66);
        check_output("early_q",        Q,           32'h66554433);
        check_output("early_fv",       32'(frame_valid), 32'd1);

        // Missing sync at frame start: fall back to hunting
        apply_stimulus(1'b1, 1'b0, 8'h77);
        check_output("miss_err",       32'(sync_err), 32'd1);
        check_output("miss_locked",    32'(locked), 32'd0);
        check_output("miss_sel",       32'(sel),    32'd0);
        check_output("miss_q_hold",    Q,           32'h66554433);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("miss_err_pulse", 32'(sync_err), 32'd0);
        apply_stimulus(1'b1, 1'b1, 8'h88);
        check_output("relock",         32'(locked), 32'd1);
        apply_stimulus(1'b1, 1'b0, 8'h99);
        apply_stimulus(1'b1, 1'b0, 8'hAA);
        apply_stimulus(1'b1, 1'b0, 8'hBB);
        check_output("relock_q",       Q,           32'hBBAA9988);
        check_output("relock_fv",      32'(frame_valid), 32'd1);

        // Reset mid-frame after slot 2
        apply_stimulus(1'b1, 1'b1, 8'hCC);
        apply_stimulus(1'b1, 1'b0, 8'hDD);
        apply_stimulus(1'b1, 1'b0, 8'hEE);
        check_output("mid_sel3",       32'(sel),    32'd3);
        valid_in = 1'b0;
        sync     = 1'b0;
        rst_n    = 1'b0;
        #2;
        check_output("mid_rst_q",      Q,           32'h0);
        check_output("mid_rst_sel",    32'(sel),    32'd0);
        check_output("mid_rst_locked", 32'(locked), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b0, 8'hFF);
        check_output("post_rst_fv",    32'(frame_valid), 32'd0);
        check_output("post_rst_hunt",  32'(locked), 32'd0);
        check_output("post_rst_q",     Q,           32'h0);
        apply_stimulus(1'b1, 1'b1, 8'h21);
        apply_stimulus(1'b1, 1'b0, 8'h43);
        apply_stimulus(1'b1, 1'b0, 8'h65);
        apply_stimulus(1'b1, 1'b0, 8'h87);
        check_output("post_rst_frame", Q,           32'h87654321);
        check_output("post_rst_fv2",   32'(frame_valid), 32'd1);
        apply_stimulus(1'b0, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1in_4out.md
Name: tdm_demux_1in_4out

Overview:
- Time-division demultiplexer: the receive end of the 4-into-1 selection path.
- Accepts a serial stream of samples with a frame-sync marker on slot 0.
- Routes each sample to one of 4 channel slots in a shadow buffer.
- Publishes all 4 channels atomically once per complete frame; detects and recovers from sync misalignment.

Parameters:
- WIDTH, 1, bits per sample / per channel.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- D  input  WIDTH  serial sample in.
- valid_in  input  1  D is valid this cycle; no backpressure, a sample is consumed every valid cycle.
- sync  input  1  qualified by valid_in; marks the sample as slot 0 of a frame.
- Q  output  4*WIDTH  published channels; Q[WIDTH*k +: WIDTH] = channel k (I[k] equivalent).
- frame_valid  output  1  one-cycle pulse: Q just updated with a complete frame.
- sel  output  2  slot index the next accepted sample will be written to.
- locked  output  1  high in state LOCKED.
- sync_err  output  1  one-cycle pulse: frame misalignment detected.

Behaviour:
- Reset (rst_n low, async): Q=0, shadow=0, sel=0, frame_valid=0, locked=0, sync_err=0, state=HUNT. All outputs are registered.
- Idle cycles: valid_in=0 holds all state; frame_valid and sync_err deassert.
- State HUNT:
  - valid_in=1 with sync=0: sample discarded, no output change.
  - valid_in=1 with sync=1: shadow[0]<=D, sel<=1, state<=LOCKED.
- State LOCKED, valid_in=1:
  - sync=0, sel!=0: shadow[sel]<=D; sel<=sel+1 (2-bit wrap 3->0).
  - sel==3 and sync=0: same edge also loads Q<={D,shadow[2],shadow[1],shadow[0]} and pulses frame_valid for the next cycle.
  - Latency: Q and frame_valid change on the edge that accepts slot 3; both are visible the following cycle.
  - sync=1 with sel==0: normal frame start, shadow[0]<=D, sel<=1.
  - sync=1 with sel!=0 (early sync): sync_err pulse; partial frame dropped; Q unchanged; shadow[0]<=D, sel<=1; remain LOCKED.
  - sync=0 with sel==0 (missing sync): sync_err pulse; sample discarded; state<=HUNT, sel stays 0.
- Q holds its last complete frame indefinitely; it is never partially updated.
- Shadow entries of a dropped frame are stale but never published, since every frame rewrites slots 0..3 before publishing.
- Reset asserted mid-frame: immediate return to HUNT, Q cleared, no frame_valid pulse.
- sync with valid_in=0 is ignored.

Decomposition:
- Shared header (tdm_defs.vh): slot-count localparam NSLOT=4, slot index width 2, state encodings HUNT=1'b0 and LOCKED=1'b1.
- One natural sub-module: tdm_slot_counter (2-bit wrapping counter with sync-load to 1 and clear), owning sel.
- Output register bank and FSM stay in the top module.

Test Plan:
- Reset then idle: rst_n=0 mid-run → Q=0, sel=0, locked=0, frame_valid=0 immediately, without waiting for a clock edge.
- Clean frame, WIDTH=8: valid stream A1(sync),B2,C3,D4 on consecutive cycles → one cycle after D4, Q=0xD4C3B2A1, frame_valid pulse exactly 1 cycle, locked=1.
- Gapped frame: same 4 samples with valid_in=0 gaps of 1–3 cycles → identical Q, single frame_valid, sel holds across gaps.
- Early sync: 11(sync),22,33(sync),44,55,66 → sync_err on 33; Q becomes 0x66554433 only; 0x22 is never published.
- Missing sync: after a full frame, send 77 with sync=0 → sync_err, locked=0, Q unchanged; next 88(sync),... relocks.
- Hunt discard then reset mid-frame: samples before the first sync are ignored; rst_n pulse after slot 2 → Q=0, next frame needs a fresh sync.
